// File: rtl/sha256_iter_core.sv
// Iterative SHA-256 compression core: UNROLL rounds per clock over 64/UNROLL cycles,
// with valid/ready handshakes and an optional internal second hash of the digest.
module sha256_iter_core #(
    parameter int           UNROLL = 1,
    parameter logic [255:0] IV     = 256'h5be0cd191f83d9ab9b05688c510e527fa54ff53a3c6ef372bb67ae856a09e667
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] in_state,
    input  logic [511:0] in_data,
    input  logic         in_double,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] out_hash
);
    localparam int R  = 64 / UNROLL;
    localparam int CW = (R > 1) ? $clog2(R) : 1;

    generate
        if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 || UNROLL == 16)) begin : g_bad_unroll
            $error("sha256_iter_core: UNROLL must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [2:0] {IDLE, RUN1, FIN1, RUN2, FIN2, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          dbl;
    logic [31:0]   wk    [8];
    logic [31:0]   chain [8];
    logic [31:0]   win   [16];

    logic [31:0]   ext [16+UNROLL];
    logic [31:0]   rnd [UNROLL+1][8];
    logic [255:0]  digest;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    assign in_ready = (state == IDLE) && !reset;

    // Schedule is extended by UNROLL words so the window can slide a full step per clock.
    always_comb begin
        logic [31:0] t1;
        logic [31:0] t2;
        logic [5:0]  kidx;
        t1   = '0;
        t2   = '0;
        kidx = '0;
        for (int i = 0; i < 16; i++) ext[i] = win[i];
        for (int i = 16; i < 16 + UNROLL; i++)
            ext[i] = ssig1(ext[i-2]) + ext[i-7] + ssig0(ext[i-15]) + ext[i-16];
        for (int k = 0; k < 8; k++) rnd[0][k] = wk[k];
        for (int j = 0; j < UNROLL; j++) begin
            kidx = 6'(int'(cnt) * UNROLL + j);
            t1 = rnd[j][7] + bsig1(rnd[j][4]) + ch(rnd[j][4], rnd[j][5], rnd[j][6]) + K[kidx] + ext[j];
            t2 = bsig0(rnd[j][0]) + maj(rnd[j][0], rnd[j][1], rnd[j][2]);
            rnd[j+1][0] = t1 + t2;
            rnd[j+1][1] = rnd[j][0];
            rnd[j+1][2] = rnd[j][1];
            rnd[j+1][3] = rnd[j][2];
            rnd[j+1][4] = rnd[j][3] + t1;
            rnd[j+1][5] = rnd[j][4];
            rnd[j+1][6] = rnd[j][5];
            rnd[j+1][7] = rnd[j][6];
        end
        digest = '0;
        for (int k = 0; k < 8; k++) digest[32*k +: 32] = chain[k] + wk[k];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_hash  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int k = 0; k < 8; k++) begin
                            wk[k]    <= in_state[32*k +: 32];
                            chain[k] <= in_state[32*k +: 32];
                        end
                        for (int i = 0; i < 16; i++) win[i] <= in_data[32*i +: 32];
                        dbl   <= in_double;
                        cnt   <= '0;
                        state <= RUN1;
                    end
                end
                RUN1, RUN2: begin
                    for (int k = 0; k < 8; k++) wk[k] <= rnd[UNROLL][k];
                    for (int i = 0; i < 16; i++) win[i] <= ext[i+UNROLL];
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(R - 1)) begin
                        cnt   <= '0;
                        state <= (state == RUN1) ? FIN1 : FIN2;
                    end
                end
                FIN1: begin
                    if (dbl) begin
                        // Second block: 32-byte digest, 0x80 pad byte, bit length 256.
                        for (int k = 0; k < 8; k++) begin
                            wk[k]    <= IV[32*k +: 32];
                            chain[k] <= IV[32*k +: 32];
                            win[k]   <= digest[32*k +: 32];
                        end
                        win[8] <= 32'h80000000;
                        for (int i = 9; i < 15; i++) win[i] <= '0;
                        win[15] <= 32'h00000100;
                        state   <= RUN2;
                    end else begin
                        out_hash  <= digest;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                FIN2: begin
                    out_hash  <= digest;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_iter_core.sv
// Bench for sha256_iter_core: one instance per UNROLL value, selected by sel,
// compared against a straightforward 64-round SHA-256 reference.
module tb_sha256_iter_core;
    localparam logic [255:0] IV = 256'h5be0cd191f83d9ab9b05688c510e527fa54ff53a3c6ef372bb67ae856a09e667;
    localparam logic [255:0] ABC_SINGLE = 256'hf20015ad_b410ff61_96177a9c_b00361a3_5dae2223_414140de_8f01cfea_ba7816bf;
    localparam logic [255:0] ABC_DOUBLE = 256'h3e6c6358_d5128cc0_05daed5a_5b2d606d_8d2da7cc_519ba6f6_2dd3729b_4f8b42c2;
    localparam int NU = 5;
    localparam int UL [NU] = '{1, 2, 4, 8, 16};

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_double;
    logic         out_ready;
    logic [255:0] in_state;
    logic [511:0] in_data;
    int           sel;

    logic [NU-1:0] rdy_v;
    logic [NU-1:0] ov_v;
    logic [255:0]  hash_v [NU];

    wire          in_ready  = rdy_v[sel];
    wire          out_valid = ov_v[sel];
    wire  [255:0] out_hash  = hash_v[sel];

    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NU; g++) begin : g_dut
        sha256_iter_core #(.UNROLL(UL[g])) dut (
            .clk      (clk),
            .reset    (reset),
            .in_valid (in_valid && (sel == g)),
            .in_ready (rdy_v[g]),
            .in_state (in_state),
            .in_data  (in_data),
            .in_double(in_double),
            .out_valid(ov_v[g]),
            .out_ready(out_ready && (sel == g)),
            .out_hash (hash_v[g])
        );
    end

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] st, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2;
        logic [255:0] r;
        for (int t = 0; t < 16; t++) w[t] = blk[32*t +: 32];
        for (int t = 16; t < 64; t++)
            w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        for (int k = 0; k < 8; k++) v[k] = st[32*k +: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int k = 0; k < 8; k++) r[32*k +: 32] = st[32*k +: 32] + v[k];
        return r;
    endfunction

    function automatic logic [255:0] hash_ref(input logic [255:0] st, input logic [511:0] blk, input logic dbl);
        logic [255:0] d;
        logic [511:0] b2;
        d = compress(st, blk);
        if (!dbl) return d;
        b2 = '0;
        b2[255:0]   = d;
        b2[287:256] = 32'h80000000;
        b2[511:480] = 32'h00000100;
        return compress(IV, b2);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rand_block(output logic [511:0] b);
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    endtask

    task automatic rand_state(output logic [255:0] s);
        for (int i = 0; i < 8; i++) s[32*i +: 32] = $urandom;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 300) begin
            step();
            lat++;
        end
    endtask

    // One full request: accept, scramble inputs, wait, stall, release.
    task automatic run_job(input int s, input logic [255:0] st, input logic [511:0] blk, input logic dbl,
                           input int stall, input bit rnd_ready, input string tag, output logic [255:0] h);
        int n, lat, r;
        logic [255:0] exp, junk_s;
        logic [511:0] junk_b;
        r   = 64 / UL[s];
        exp = hash_ref(st, blk, dbl);
        sel = s; in_state = st; in_data = blk; in_double = dbl; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 300) begin
            step();
            n++;
        end
        chk({tag, " in_ready"}, 256'(in_ready), 256'(1));
        step();
        in_valid = 1'b0;
        rand_state(junk_s); rand_block(junk_b);
        in_state = junk_s; in_data = junk_b; in_double = ~dbl;
        lat = 0;
        while (!out_valid && lat < 300) begin
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            lat++;
        end
        out_ready = 1'b0;
        chk({tag, " latency"}, 256'(lat), 256'(dbl ? 2*r + 2 : r + 1));
        h = out_hash;
        chk({tag, " digest"}, h, exp);
        for (int i = 0; i < stall; i++) begin
            step();
            chk({tag, " hold"}, {out_valid, in_ready, out_hash}, {1'b1, 1'b0, h});
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, " release"}, 256'({out_valid, in_ready}), 256'(2'b01));
    endtask

    logic [511:0] abc, blk_a, blk_r;
    logic [255:0] st_r, h;
    int lat;
    int sweep_sel [4] = '{0, 1, 3, 4};

    initial begin
        abc = '0;
        abc[31:0]    = 32'h61626380;
        abc[511:480] = 32'h00000018;
        reset = 1'b1; in_valid = 1'b0; in_double = 1'b0; out_ready = 1'b0;
        in_state = '0; in_data = '0; sel = 0;

        // Reset state
        repeat (3) step();
        chk("reset u1", {out_valid, in_ready, out_hash}, {2'b00, 256'd0});
        sel = 4;
        chk("reset u16", {out_valid, in_ready, out_hash}, {2'b00, 256'd0});
        reset = 1'b0;
        #1;
        chk("reset release", 256'(in_ready), 256'(1));

        // "abc" single, UNROLL=1
        run_job(0, IV, abc, 1'b0, 0, 1'b0, "abc u1", h);
        chk("abc u1 known", h, ABC_SINGLE);

        // "abc" double, UNROLL=4, with 10 cycles of backpressure
        run_job(2, IV, abc, 1'b1, 10, 1'b0, "abc u4 dbl", h);
        chk("abc u4 dbl known", h, ABC_DOUBLE);

        // Reset 20 cycles into RUN1
        sel = 0; in_state = IV; in_data = abc; in_double = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (20) step();
        reset = 1'b1;
        step();
        chk("mid reset", {out_valid, in_ready, out_hash}, {2'b00, 256'd0});
        reset = 1'b0;
        #1;
        chk("mid reset ready", 256'(in_ready), 256'(1));
        run_job(0, IV, abc, 1'b0, 0, 1'b0, "after reset", h);
        chk("after reset known", h, ABC_SINGLE);

        // Back-to-back with in_valid held, UNROLL=2
        rand_block(blk_a);
        sel = 1; in_state = IV; in_data = blk_a; in_double = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_data = abc;
        wait_valid(lat);
        chk("b2b first latency", 256'(lat), 256'(33));
        chk("b2b first digest", out_hash, hash_ref(IV, blk_a, 1'b0));
        step();
        chk("b2b handshake", 256'({out_valid, in_ready}), 256'(2'b01));
        step();
        chk("b2b second accepted", 256'(in_ready), 256'(0));
        in_valid = 1'b0;
        rand_block(blk_r);
        in_data = blk_r;
        wait_valid(lat);
        chk("b2b second latency", 256'(lat), 256'(33));
        chk("b2b second digest", out_hash, ABC_SINGLE);
        step();
        out_ready = 1'b0;
        chk("b2b second release", 256'({out_valid, in_ready}), 256'(2'b01));

        // Random sweep over UNROLL 1, 2, 8, 16
        for (int i = 0; i < 100; i++) begin
            rand_state(st_r);
            rand_block(blk_r);
            run_job(sweep_sel[i % 4], st_r, blk_r, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b1,
                    $sformatf("sweep%0d u%0d", i, UL[sweep_sel[i % 4]]), h);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
